ram_phase_sequencer: RTL and testbench

//  Owns the single-port data RAM and sequences the three system phases: UART load, CPU process, UART transmit.

---
 rtl/ram_phase_sequencer_pkg.sv | 17 +
 rtl/ram_phase_sequencer_if.sv | 50 +++++
 rtl/ram_phase_sequencer_ram_port_mux.sv | 50 +++++
 rtl/ram_phase_sequencer.sv | 78 +++++++
 tb/tb_ram_phase_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ram_phase_sequencer_pkg.sv
// ram_phase_sequencer_pkg: shared state encoding, RAM owner select and default bus widths
package ram_phase_sequencer_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {
    S_RECEIVE  = 3'd0,
    S_PROCESS  = 3'd1,
    S_TRANSMIT = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_UART = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;
endpackage

// File: rtl/ram_phase_sequencer_if.sv
// ram_phase_sequencer_if: UART/CPU request ports, phase control and RAM outputs of the sequencer
// Signals:
//   uart_req/we/addr/data -> uart_gnt   bridge RAM cycle request and grant
//   cpu_req/we/addr/data  -> cpu_gnt    CPU RAM cycle request and grant
//   rx_byte_done, tx_byte_done, process_finished, restart   phase events
//   start_processing, start_transmission, phase, timeout_err phase status
//   ram_wren, ram_address, ram_data                         RAM write port
// Modports: slave = sequencer, master = the block driving requests/events.
interface ram_phase_sequencer_if
  import ram_phase_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              uart_req;
  logic              uart_we;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_data;
  logic              uart_gnt;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_gnt;
  logic              rx_byte_done;
  logic              tx_byte_done;
  logic              process_finished;
  logic              restart;
  logic              start_processing;
  logic              start_transmission;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [2:0]        phase;
  logic              timeout_err;
  modport slave (
    input  uart_req, uart_we, uart_addr, uart_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_data,
    input  rx_byte_done, tx_byte_done, process_finished, restart,
    output uart_gnt, cpu_gnt, start_processing, start_transmission,
    output ram_wren, ram_address, ram_data, phase, timeout_err
  );
  modport master (
    output uart_req, uart_we, uart_addr, uart_data,
    output cpu_req, cpu_we, cpu_addr, cpu_data,
    output rx_byte_done, tx_byte_done, process_finished, restart,
    input  uart_gnt, cpu_gnt, start_processing, start_transmission,
    input  ram_wren, ram_address, ram_data, phase, timeout_err
  );
endinterface

// File: rtl/ram_phase_sequencer_ram_port_mux.sv
// ram_port_mux: registered 2:1 RAM request/grant mux, the current owner's request wins
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   owner                        which requester may use the RAM this cycle
//   uart_*/cpu_* req/we/addr/data  requests; *_gnt registered grants
//   ram_wren/ram_addr/ram_data   registered RAM port; addr/data hold when idle
module ram_port_mux
  import ram_phase_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  owner_t            owner,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              uart_gnt,
  output logic              cpu_gnt,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data
);
  logic uart_sel, cpu_sel;
  assign uart_sel = (owner == OWN_UART) && uart_req;
  assign cpu_sel  = (owner == OWN_CPU) && cpu_req;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_gnt <= 1'b0;
      cpu_gnt  <= 1'b0;
      ram_wren <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      uart_gnt <= uart_sel;
      cpu_gnt  <= cpu_sel;
      ram_wren <= (uart_sel && uart_we) || (cpu_sel && cpu_we);
      if (uart_sel || cpu_sel) begin
        ram_addr <= uart_sel ? uart_addr : cpu_addr;
        ram_data <= uart_sel ? uart_data : cpu_data;
      end
    end
  end
endmodule

// File: rtl/ram_phase_sequencer.sv
// ram_phase_sequencer: RAM owner FSM sequencing UART load, CPU process and UART transmit
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ram_phase_sequencer_if.slave: requests/grants, phase events, RAM port, status
// Parameters: LOAD_BYTES/STORE_BYTES byte counts per phase, TIMEOUT_CYCLES watchdog (0 = off).
module ram_phase_sequencer
  import ram_phase_sequencer_pkg::*;
#(
  parameter int          ADDR_W         = DEF_ADDR_W,
  parameter int          DATA_W         = DEF_DATA_W,
  parameter logic [15:0] LOAD_BYTES     = 16'd256,
  parameter logic [15:0] STORE_BYTES    = 16'd256,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_phase_sequencer_if.slave bus
);
  state_t      state, state_nx;
  owner_t      owner;
  logic [15:0] rx_cnt, tx_cnt;
  logic [23:0] wd_cnt;
  logic        timeout_hit;
  assign owner = (state == S_RECEIVE || state == S_TRANSMIT) ? OWN_UART :
                 (state == S_PROCESS) ? OWN_CPU : OWN_NONE;
  assign timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (wd_cnt == TIMEOUT_CYCLES - 24'd1);
  assign bus.phase = state;
  always_comb begin
    state_nx = state;
    case (state)
      S_RECEIVE:  state_nx = (rx_cnt == LOAD_BYTES) ? S_PROCESS : S_RECEIVE;
      S_PROCESS:  state_nx = bus.process_finished ? S_TRANSMIT : timeout_hit ? S_ERROR : S_PROCESS;
      S_TRANSMIT: state_nx = (tx_cnt == STORE_BYTES) ? S_DONE : S_TRANSMIT;
      S_DONE:     state_nx = bus.restart ? S_RECEIVE : S_DONE;
      S_ERROR:    state_nx = bus.restart ? S_RECEIVE : S_ERROR;
      default:    state_nx = S_RECEIVE;
    endcase
  end
  // Counters live only inside their own phase, so leaving a phase (or restarting) clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_RECEIVE;
      rx_cnt             <= '0;
      tx_cnt             <= '0;
      wd_cnt             <= '0;
      bus.start_processing   <= 1'b0;
      bus.start_transmission <= 1'b0;
      bus.timeout_err        <= 1'b0;
    end else begin
      state  <= state_nx;
      rx_cnt <= (state != S_RECEIVE || rx_cnt == LOAD_BYTES) ? '0 : rx_cnt + {15'd0, bus.rx_byte_done};
      tx_cnt <= (state != S_TRANSMIT || tx_cnt == STORE_BYTES) ? '0 : tx_cnt + {15'd0, bus.tx_byte_done};
      wd_cnt <= (state == S_PROCESS) ? wd_cnt + 24'd1 : '0;
      bus.start_processing   <= state_nx == S_PROCESS;
      bus.start_transmission <= state_nx == S_TRANSMIT;
      bus.timeout_err        <= state_nx == S_ERROR;
    end
  end
  ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .owner     (owner),
    .uart_req  (bus.uart_req),
    .uart_we   (bus.uart_we),
    .uart_addr (bus.uart_addr),
    .uart_data (bus.uart_data),
    .cpu_req   (bus.cpu_req),
    .cpu_we    (bus.cpu_we),
    .cpu_addr  (bus.cpu_addr),
    .cpu_data  (bus.cpu_data),
    .uart_gnt  (bus.uart_gnt),
    .cpu_gnt   (bus.cpu_gnt),
    .ram_wren  (bus.ram_wren),
    .ram_addr  (bus.ram_address),
    .ram_data  (bus.ram_data)
  );
endmodule

// File: tb/tb_ram_phase_sequencer.sv
// tb_ram_phase_sequencer: directed checks of two sequencer instances (watchdog off / watchdog 50)
module tb_ram_phase_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  ram_phase_sequencer_if ia ();
  ram_phase_sequencer_if ib ();
  ram_phase_sequencer #(.LOAD_BYTES(16'd4), .STORE_BYTES(16'd2), .TIMEOUT_CYCLES(24'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  ram_phase_sequencer #(.LOAD_BYTES(16'd8), .STORE_BYTES(16'd2), .TIMEOUT_CYCLES(24'd50)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] load_data [4];
    load_data = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    {ia.uart_req, ia.uart_we, ia.uart_addr, ia.uart_data} = '0;
    {ia.cpu_req, ia.cpu_we, ia.cpu_addr, ia.cpu_data} = '0;
    {ia.rx_byte_done, ia.tx_byte_done, ia.process_finished, ia.restart} = '0;
    {ib.uart_req, ib.uart_we, ib.uart_addr, ib.uart_data} = '0;
    {ib.cpu_req, ib.cpu_we, ib.cpu_addr, ib.cpu_data} = '0;
    {ib.rx_byte_done, ib.tx_byte_done, ib.process_finished, ib.restart} = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_phase", 32'(ia.phase), 0);
    chk("rst_a_outs", 32'({ia.uart_gnt, ia.cpu_gnt, ia.ram_wren, ia.start_processing, ia.start_transmission, ia.timeout_err}), 0);
    chk("rst_a_addr", 32'(ia.ram_address), 0);
    tick();
    tick();
    rst_n = 1'b1;
    // reset in the middle of RECEIVE (dut_b, rx_cnt=5)
    {ib.uart_req, ib.uart_we, ib.uart_addr, ib.uart_data} = {1'b1, 1'b1, 16'h0007, 8'h11};
    ib.rx_byte_done = 1'b1;
    repeat (5) tick();
    chk("b_pre_rst_wren", 32'(ib.ram_wren), 1);
    chk("b_pre_rst_addr", 32'(ib.ram_address), 32'h7);
    #1 rst_n = 1'b0;
    #1;
    chk("b_mid_rst_phase", 32'(ib.phase), 0);
    chk("b_mid_rst_outs", 32'({ib.uart_gnt, ib.cpu_gnt, ib.ram_wren, ib.start_processing, ib.start_transmission, ib.timeout_err}), 0);
    chk("b_mid_rst_addr", 32'(ib.ram_address), 0);
    chk("b_mid_rst_data", 32'(ib.ram_data), 0);
    {ib.uart_req, ib.uart_we} = '0;
    rst_n = 1'b1;
    repeat (7) tick();
    ib.rx_byte_done = 1'b0;
    tick();
    chk("b_7_bytes_phase", 32'(ib.phase), 0);
    ib.rx_byte_done = 1'b1;
    tick();
    ib.rx_byte_done = 1'b0;
    tick();
    chk("b_8_bytes_phase", 32'(ib.phase), 1);
    chk("b_8_bytes_sp", 32'(ib.start_processing), 1);
    // watchdog: 50 cycles in PROCESS without FINISHED
    repeat (49) tick();
    chk("b_wd49_phase", 32'(ib.phase), 1);
    chk("b_wd49_err", 32'(ib.timeout_err), 0);
    tick();
    chk("b_wd50_phase", 32'(ib.phase), 4);
    chk("b_wd50_err", 32'(ib.timeout_err), 1);
    chk("b_wd50_sp", 32'(ib.start_processing), 0);
    ib.restart = 1'b1;
    tick();
    ib.restart = 1'b0;
    chk("b_restart_phase", 32'(ib.phase), 0);
    chk("b_restart_err", 32'(ib.timeout_err), 0);
    // dut_a load of four bytes
    for (int i = 0; i < 4; i++) begin
      {ia.uart_req, ia.uart_we, ia.uart_addr, ia.uart_data} = {1'b1, 1'b1, 16'(i), load_data[i]};
      ia.rx_byte_done = 1'b1;
      tick();
      chk("a_load_wren", 32'(ia.ram_wren), 1);
      chk("a_load_addr", 32'(ia.ram_address), 32'(i));
      chk("a_load_data", 32'(ia.ram_data), 32'(load_data[i]));
      chk("a_load_gnt", 32'(ia.uart_gnt), 1);
      chk("a_load_phase", 32'(ia.phase), 0);
    end
    {ia.uart_req, ia.uart_we, ia.rx_byte_done} = '0;
    tick();
    chk("a_proc_phase", 32'(ia.phase), 1);
    chk("a_proc_sp", 32'(ia.start_processing), 1);
    chk("a_idle_wren", 32'(ia.ram_wren), 0);
    chk("a_idle_addr_hold", 32'(ia.ram_address), 3);
    // contention in PROCESS: only the CPU is served
    {ia.uart_req, ia.uart_we, ia.uart_addr, ia.uart_data} = {1'b1, 1'b1, 16'h0010, 8'h77};
    {ia.cpu_req, ia.cpu_we, ia.cpu_addr, ia.cpu_data} = {1'b1, 1'b1, 16'h0020, 8'h3C};
    tick();
    chk("a_cpu_wr_wren", 32'(ia.ram_wren), 1);
    chk("a_cpu_wr_addr", 32'(ia.ram_address), 32'h20);
    chk("a_cpu_wr_data", 32'(ia.ram_data), 32'h3C);
    chk("a_cpu_gnt", 32'(ia.cpu_gnt), 1);
    chk("a_uart_gnt_blocked", 32'(ia.uart_gnt), 0);
    ia.uart_req = 1'b0;
    {ia.cpu_we, ia.cpu_addr} = {1'b0, 16'h0021};
    tick();
    chk("a_cpu_rd_wren", 32'(ia.ram_wren), 0);
    chk("a_cpu_rd_gnt", 32'(ia.cpu_gnt), 1);
    chk("a_cpu_rd_addr", 32'(ia.ram_address), 32'h21);
    ia.cpu_req = 1'b0;
    ia.restart = 1'b1;
    tick();
    ia.restart = 1'b0;
    chk("a_restart_ignored", 32'(ia.phase), 1);
    repeat (99) tick();
    chk("a_no_wd_phase", 32'(ia.phase), 1);
    // FINISHED on the same edge as a CPU write: that write is still granted
    ia.process_finished = 1'b1;
    {ia.cpu_req, ia.cpu_we, ia.cpu_addr, ia.cpu_data} = {1'b1, 1'b1, 16'h0030, 8'h99};
    tick();
    ia.process_finished = 1'b0;
    chk("a_tx_phase", 32'(ia.phase), 2);
    chk("a_tx_st", 32'(ia.start_transmission), 1);
    chk("a_tx_sp", 32'(ia.start_processing), 0);
    chk("a_handover_gnt", 32'(ia.cpu_gnt), 1);
    chk("a_handover_addr", 32'(ia.ram_address), 32'h30);
    {ia.cpu_addr, ia.cpu_data} = {16'h0031, 8'h44};
    {ia.uart_req, ia.uart_we, ia.uart_addr} = {1'b1, 1'b0, 16'h0005};
    tick();
    chk("a_tx_cpu_gnt", 32'(ia.cpu_gnt), 0);
    chk("a_tx_uart_gnt", 32'(ia.uart_gnt), 1);
    chk("a_tx_wren", 32'(ia.ram_wren), 0);
    chk("a_tx_addr", 32'(ia.ram_address), 32'h5);
    {ia.cpu_req, ia.uart_req} = '0;
    ia.tx_byte_done = 1'b1;
    tick();
    chk("a_tx1_phase", 32'(ia.phase), 2);
    tick();
    ia.tx_byte_done = 1'b0;
    chk("a_tx2_phase", 32'(ia.phase), 2);
    chk("a_tx2_st", 32'(ia.start_transmission), 1);
    tick();
    chk("a_done_phase", 32'(ia.phase), 3);
    chk("a_done_st", 32'(ia.start_transmission), 0);
    ia.restart = 1'b1;
    tick();
    ia.restart = 1'b0;
    chk("a_done_restart", 32'(ia.phase), 0);
    // dut_b: stray TX pulses in RECEIVE, then FINISHED together with timeout
    ib.tx_byte_done = 1'b1;
    repeat (3) tick();
    ib.tx_byte_done = 1'b0;
    ib.rx_byte_done = 1'b1;
    repeat (8) tick();
    ib.rx_byte_done = 1'b0;
    tick();
    chk("b_reload_phase", 32'(ib.phase), 1);
    repeat (49) tick();
    ib.process_finished = 1'b1;
    tick();
    ib.process_finished = 1'b0;
    chk("b_tie_phase", 32'(ib.phase), 2);
    chk("b_tie_err", 32'(ib.timeout_err), 0);
    ib.tx_byte_done = 1'b1;
    tick();
    ib.tx_byte_done = 1'b0;
    tick();
    chk("b_stray_tx_phase", 32'(ib.phase), 2);
    ib.tx_byte_done = 1'b1;
    tick();
    ib.tx_byte_done = 1'b0;
    tick();
    chk("b_done_phase", 32'(ib.phase), 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
